// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: memory-mapped prescaled 32-bit timer on the CPU data port.
// Ports: clk, Reset (sync, active-high), MemWrite, DataAddress[31:0], WriteData[31:0]
//        in; ReadData[31:0] (combinational, 0 when !hit), hit out; irq out when
//        TIMER_IRQ_EN is defined (adds CTRL bit3 IRQEN).
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
`ifdef TIMER_IRQ_EN
    output logic        irq,
`endif
    output logic        hit
);

`ifdef TIMER_IRQ_EN
    localparam int unsigned CTRL_W = 4;
`else
    localparam int unsigned CTRL_W = 3;
`endif

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_COUNT  = 3'd1;
    localparam logic [2:0] OFF_CMP    = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    localparam logic [PRESC_W-1:0] PONE = 1;

    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic [1:0]         status_q, status_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;

    logic [2:0]  offset;
    logic        wr;
    logic        wr_ctrl, wr_count, wr_cmp, wr_status, wr_presc;
    logic        tick;
    logic        is_match;
    logic        match_set, ovf_set;
    logic [32:0] count_inc;
    logic        unused_addr;

    assign hit    = (DataAddress[31:5] == BASE_ADDR[31:5]);
    assign offset = DataAddress[4:2];
    assign wr     = MemWrite && hit;

    assign wr_ctrl   = wr && (offset == OFF_CTRL);
    assign wr_count  = wr && (offset == OFF_COUNT);
    assign wr_cmp    = wr && (offset == OFF_CMP);
    assign wr_status = wr && (offset == OFF_STATUS);
    assign wr_presc  = wr && (offset == OFF_PRESC);

    assign unused_addr = ^DataAddress[1:0];

    assign tick      = ctrl_q[0] && (pcnt_q == presc_q);
    assign is_match  = (count_q == compare_q);
    assign count_inc = {1'b0, count_q} + 33'd1;

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        presc_d   = presc_q;
        match_set = 1'b0;
        ovf_set   = 1'b0;

        // A CPU write to COUNT on a tick edge suppresses the whole tick.
        if (tick && !wr_count) begin
            if (is_match) begin
                match_set = 1'b1;
                if (ctrl_q[2]) ctrl_d[0] = 1'b0;
            end
            if (is_match && ctrl_q[1]) begin
                count_d = '0;
            end else begin
                count_d = count_inc[31:0];
                ovf_set = count_inc[32];
            end
        end

        if (wr_ctrl)  ctrl_d    = WriteData[CTRL_W-1:0];
        if (wr_count) count_d   = WriteData;
        if (wr_cmp)   compare_d = WriteData;
        if (wr_presc) presc_d   = WriteData[PRESC_W-1:0];

        // W1C first, then new events, so a same-edge set survives the clear.
        status_d = status_q & ~({2{wr_status}} & WriteData[1:0]);
        status_d = status_d | {ovf_set, match_set};

        // Prescaler restarts from 0 whenever the timer is (or becomes) idle.
        if (!ctrl_q[0] || !ctrl_d[0] || wr_presc || tick)
            pcnt_d = '0;
        else
            pcnt_d = pcnt_q + PONE;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            status_q  <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
        end
    end

    always_comb begin
        ReadData = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   ReadData = 32'(ctrl_q);
                OFF_COUNT:  ReadData = count_q;
                OFF_CMP:    ReadData = compare_q;
                OFF_STATUS: ReadData = 32'(status_q);
                OFF_PRESC:  ReadData = 32'(presc_q);
                default:    ReadData = '0;
            endcase
        end
    end

`ifdef TIMER_IRQ_EN
    assign irq = ctrl_q[3] & (|status_q);
`endif

endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb_mmio_timer_responder: directed plus randomized checks of mmio_timer_responder
// against a per-cycle reference model of the register map and timer rules.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef TIMER_IRQ_EN
    localparam logic [31:0] CMASK = 32'hF;
`else
    localparam logic [31:0] CMASK = 32'h7;
`endif

    logic        clk;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
`ifdef TIMER_IRQ_EN
    logic        irq;
`endif

    int total;
    int bad;

    logic [31:0] m_ctrl, m_count, m_compare, m_status, m_presc;
    int unsigned m_pcnt;

    mmio_timer_responder dut (
        .clk         (clk),
        .Reset       (Reset),
        .MemWrite    (MemWrite),
        .DataAddress (DataAddress),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
`ifdef TIMER_IRQ_EN
        .irq         (irq),
`endif
        .hit         (hit)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock of the timer, derived from the register-map rules.
    task automatic m_step(input bit rst, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
        bit          h;
        int unsigned off;
        bit          tk;
        bit          setm;
        bit          seto;
        logic [31:0] nctrl;
        logic [31:0] ncount;
        logic [31:0] clr;
        longint unsigned v;
        int unsigned npcnt;
        if (rst) begin
            m_ctrl = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
            m_status = 0; m_presc = 0; m_pcnt = 0;
        end else begin
            h = (a >> 5) == (BASE >> 5);
            off = (a >> 2) & 7;
            tk = m_ctrl[0] && (m_pcnt == m_presc);
            nctrl = m_ctrl; ncount = m_count;
            setm = 0; seto = 0; clr = 0;
            if (tk && !(we && h && off == 1)) begin
                if (m_count == m_compare) begin
                    setm = 1;
                    if (m_ctrl[2]) nctrl[0] = 1'b0;
                end
                if (setm && m_ctrl[1]) ncount = 0;
                else begin
                    v = longint'(m_count) + 1;
                    seto = (v > 64'hFFFF_FFFF);
                    ncount = v[31:0];
                end
            end
            if (!m_ctrl[0] || tk) npcnt = 0;
            else npcnt = m_pcnt + 1;
            if (we && h) begin
                case (off)
                    0: nctrl = d & CMASK;
                    1: ncount = d;
                    2: m_compare = d;
                    3: clr = d & 32'h3;
                    4: begin m_presc = d & 32'hFFFF; npcnt = 0; end
                    default: ;
                endcase
            end
            if (!nctrl[0]) npcnt = 0;
            m_status = (m_status & ~clr) | {30'd0, seto, setm};
            m_ctrl = nctrl;
            m_count = ncount;
            m_pcnt = npcnt;
        end
    endtask

    function automatic logic [31:0] m_read(input int unsigned off);
        case (off)
            0: return m_ctrl;
            1: return m_count;
            2: return m_compare;
            3: return m_status;
            4: return m_presc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input bit rst, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
        Reset = rst; MemWrite = we; DataAddress = a; WriteData = d;
        @(posedge clk);
        m_step(rst, we, a, d);
        #1;
        Reset = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        DataAddress = a;
        #1;
        d = ReadData;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] a;
        for (int o = 0; o < 8; o++) begin
            DataAddress = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
            #1;
            chk({tag, "_rd"}, ReadData, m_read(o));
        end
        chk({tag, "_hit"}, {31'd0, hit}, 32'd1);
        a = $urandom;
        if ((a >> 5) == (BASE >> 5)) a = a ^ 32'h0010_0000;
        DataAddress = a;
        #1;
        chk({tag, "_miss_rd"}, ReadData, 32'd0);
        chk({tag, "_miss_hit"}, {31'd0, hit}, 32'd0);
`ifdef TIMER_IRQ_EN
        chk({tag, "_irq"}, {31'd0, irq},
            {31'd0, m_ctrl[3] & (m_status[0] | m_status[1])});
`endif
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int unsigned off;
        int unsigned r;
        total = 0;
        bad = 0;
        Reset = 1'b0; MemWrite = 1'b0;
        DataAddress = 32'h0; WriteData = 32'h0;

        // Reset beats a simultaneous store
        step(1, 1, 32'h1004, 32'd5);
        step(1, 1, 32'h1004, 32'd5);
        check_all("reset");
        rd(32'h1004, d); chk("rst_count", d, 32'd0);
        rd(32'h1008, d); chk("rst_cmp", d, 32'hFFFF_FFFF);
        rd(32'h100C, d); chk("rst_status", d, 32'd0);
        rd(32'h0FFC, d); chk("rst_out_rd", d, 32'd0);
        chk("rst_out_hit", {31'd0, hit}, 32'd0);

        // Periodic auto-reload with prescaler 3
        wr(32'h1010, 32'd3);
        wr(32'h1008, 32'd2);
        wr(32'h1000, 32'd3);
        for (int i = 0; i < 11; i++) begin
            idle(1);
            check_all("periodic");
        end
        rd(32'h1004, d); chk("per_cnt2", d, 32'd2);
        rd(32'h100C, d); chk("per_nomatch", d, 32'd0);
        idle(1);
        check_all("periodic");
        rd(32'h1004, d); chk("per_reload", d, 32'd0);
        rd(32'h100C, d); chk("per_match", d, 32'd1);

        // One-shot
        wr(32'h1000, 32'd0);
        wr(32'h1004, 32'd0);
        wr(32'h100C, 32'd3);
        wr(32'h1010, 32'd0);
        wr(32'h1008, 32'd5);
        wr(32'h1000, 32'd5);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check_all("oneshot");
        end
        rd(32'h100C, d); chk("os_match", d, 32'd1);
        rd(32'h1000, d); chk("os_ctrl", d, 32'd4);
        rd(32'h1004, d); chk("os_count", d, 32'd6);
        idle(3);
        rd(32'h1004, d); chk("os_hold", d, 32'd6);

        // Overflow and W1C
        wr(32'h100C, 32'd3);
        wr(32'h1004, 32'hFFFF_FFFE);
        wr(32'h1010, 32'd0);
        wr(32'h1000, 32'd1);
        idle(2);
        check_all("ovf");
        rd(32'h1004, d); chk("ovf_count", d, 32'd0);
        rd(32'h100C, d); chk("ovf_status", d, 32'd2);
        wr(32'h100C, 32'd2);
        check_all("ovf_clr");
        rd(32'h100C, d); chk("ovf_cleared", d, 32'd0);

        // W1C on the match edge keeps MATCH
        wr(32'h1000, 32'd0);
        wr(32'h100C, 32'd3);
        wr(32'h1004, 32'd0);
        wr(32'h1008, 32'd2);
        wr(32'h1000, 32'd1);
        idle(2);
        wr(32'h100C, 32'd1);
        check_all("w1c_race");
        rd(32'h100C, d); chk("w1c_race_match", d, 32'd1);

        // COUNT write on a tick edge wins
        wr(32'h1004, 32'd100);
        check_all("cnt_race");
        rd(32'h1004, d); chk("cnt_race_val", d, 32'd100);
        idle(1);
        check_all("cnt_after");

`ifdef TIMER_IRQ_EN
        wr(32'h1000, 32'd0);
        wr(32'h100C, 32'd3);
        wr(32'h1004, 32'd0);
        wr(32'h1008, 32'd3);
        wr(32'h1010, 32'd0);
        wr(32'h1000, 32'd9);
        idle(3);
        chk("irq_low", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_high", {31'd0, irq}, 32'd1);
        wr(32'h100C, 32'd1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            off = $urandom_range(0, 7);
            case (off)
                1: begin
                    case ($urandom_range(0, 2))
                        0: d = 32'($urandom_range(0, 8));
                        1: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
                        default: d = $urandom;
                    endcase
                end
                2: d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8))
                                                   : 32'hFFFF_FFFF;
                4: d = 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
                if ((a >> 5) == (BASE >> 5)) a = a ^ 32'h0010_0000;
            end else begin
                a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            end
            if (r < 3) step(1, $urandom_range(0, 1) == 1, a, d);
            else if (r < 55) step(0, 0, a, d);
            else step(0, 1, a, d);
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
